// File: rtl/rng_stream_buf.sv
// Decimating sample buffer behind the LFSR core: samples the parallel word
// every div_i+1 enabled cycles into a show-ahead FIFO with a valid/ready output.
module rng_stream_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [DIV_WIDTH-1:0]      div_i,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     rng_dat_i,
    output logic [DATA_WIDTH-1:0]     dat_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      ovf_o,
    input  logic                      ovf_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic          samp, pop, push, drop;
    logic [PW-1:0] level;

    // Pointers carry a wrap bit, so the difference is the true fill level.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign level_o = level;
    assign full_o  = (level == PW'(DEPTH));
    assign empty_o = (level == '0);
    assign valid_o = !empty_o;
    assign dat_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign ovf_o   = ovf_q;

    assign samp = en_i && (cnt_q >= div_i);
    assign pop  = valid_o && ready_i;
    assign push = samp && (!full_o || pop);
    assign drop = samp && full_o && !pop;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (en_i) begin
            cnt_d = samp ? '0 : cnt_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        // Flush discards this cycle's sample and pop but leaves ovf alone.
        if (flush_i) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rng_dat_i;
        end
    end

endmodule
